// File: rtl/bip_dbg_pkg.sv
// Shared definitions for the BIP debug unit: FSM states, command bytes and frame geometry.
package bip_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_SEND,
    ST_WAIT_DONE
  } state_t;

  localparam logic [7:0] CMD_RUN     = 8'h67;
  localparam logic [7:0] CMD_STEP    = 8'h73;
  localparam int         FRAME_BYTES = 8;
  localparam int         IDX_W       = 3;

endpackage

// File: rtl/bip_dbg_frame_sel.sv
// Picks one byte of the 8-byte snapshot frame: acc, pc (zero-extended), cycle count, MSB first.
module bip_dbg_frame_sel
  import bip_dbg_pkg::*;
(
  input  logic [15:0]      acc,
  input  logic [15:0]      pc,
  input  logic [31:0]      cnt,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       sel_byte
);

  always_comb begin
    sel_byte = 8'h00;
    case (idx)
      3'd0: sel_byte = acc[15:8];
      3'd1: sel_byte = acc[7:0];
      3'd2: sel_byte = pc[15:8];
      3'd3: sel_byte = pc[7:0];
      3'd4: sel_byte = cnt[31:24];
      3'd5: sel_byte = cnt[23:16];
      3'd6: sel_byte = cnt[15:8];
      3'd7: sel_byte = cnt[7:0];
      default: sel_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/bip_debug_unit.sv
// Run-control for the BIP core: 'g'/'s' commands gate bip_enable, then the halt/step
// snapshot is streamed to UART TX as an 8-byte frame.
//
// state        | meaning
// ST_IDLE      | waiting for a run/step command byte
// ST_RUN       | BIP enabled, counting cycles until bip_halt
// ST_STEP      | BIP enabled for exactly one cycle
// ST_SEND      | present frame byte idx and pulse tx_start
// ST_WAIT_DONE | wait for tx_done, then next byte or back to idle
module bip_debug_unit #(
  parameter int         DATA_W   = 16,
  parameter int         PC_W     = 11,
  parameter int         CNT_W    = 32,
  parameter logic [7:0] CMD_RUN  = bip_dbg_pkg::CMD_RUN,
  parameter logic [7:0] CMD_STEP = bip_dbg_pkg::CMD_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              bip_halt,
  input  logic [DATA_W-1:0] bip_acc,
  input  logic [PC_W-1:0]   bip_pc,
  output logic              bip_enable,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy
);
  import bip_dbg_pkg::*;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                en_d, start_d, busy_d;
  logic [7:0]          data_d, sel_byte;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // The live counter doubles as the count snapshot: it only moves in RUN/STEP,
  // so it cannot change while a frame is being sent.
  bip_dbg_frame_sel u_frame_sel (
    .acc      (16'(acc_q)),
    .pc       (16'(pc_q)),
    .cnt      (32'(cnt_q)),
    .idx      (idx_q),
    .sel_byte (sel_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    en_d    = bip_enable;
    start_d = 1'b0;
    data_d  = tx_data;
    case (state_q)
      ST_IDLE: begin
        if (rx_done && rx_data == CMD_RUN) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end else if (rx_done && rx_data == CMD_STEP) begin
          state_d = ST_STEP;
          en_d    = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (bip_halt) begin
          acc_d   = bip_acc;
          pc_d    = bip_pc;
          en_d    = 1'b0;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_STEP: begin
        cnt_d   = cnt_inc;
        acc_d   = bip_acc;
        pc_d    = bip_pc;
        en_d    = 1'b0;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        data_d  = sel_byte;
        start_d = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      pc_q       <= '0;
      idx_q      <= '0;
      bip_enable <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      bip_enable <= en_d;
      tx_start   <= start_d;
      tx_data    <= data_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Scoreboard bench for bip_debug_unit: randomized run/step commands against a frame-level model.
module tb_bip_debug_unit;
  import bip_dbg_pkg::*;

  localparam int DATA_W = 16;
  localparam int PC_W   = 11;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              bip_halt;
  logic [DATA_W-1:0] bip_acc = '0;
  logic [PC_W-1:0]   bip_pc = '0;
  logic              bip_enable;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done = 1'b0;
  logic              busy;

  bip_debug_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .bip_halt   (bip_halt),
    .bip_acc    (bip_acc),
    .bip_pc     (bip_pc),
    .bip_enable (bip_enable),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // BIP stand-in: raises halt while executing its h-th enabled cycle of the current command.
  int unsigned en_cnt = 0;
  int unsigned en_base = 0;
  int unsigned halt_at = 0;
  always @(posedge clk) if (bip_enable) en_cnt <= en_cnt + 1;
  assign bip_halt = (halt_at != 0) && ((en_cnt - en_base) >= halt_at - 1);

  logic [7:0] exp_bytes[$];
  int         exp_en[$];
  int         checks = 0;
  int         errors = 0;
  bit         finish_req = 0;
  bit         final_done = 0;
  int unsigned cnt_model = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows tx_start or finishes a command.
  initial begin
    bit prev_start = 0;
    bit prev_busy  = 0;
    bit lat_active = 0;
    int lat = 0;
    int en_seen = 0;
    int frame_pos = 0;
    forever begin
      @(negedge clk);
      if (bip_enable) en_seen++;
      if (prev_busy && !busy) begin
        if (exp_en.size() == 0) check("spurious_command", 1, 0);
        else check("enable_cycles", en_seen, exp_en.pop_front());
        en_seen = 0;
      end
      prev_busy = busy;
      if (!reset) begin
        check("rst_tx_start", tx_start, 0);
        check("rst_bip_enable", bip_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        exp_bytes.delete();
        frame_pos  = 0;
        lat_active = 0;
        prev_start = 0;
        en_seen    = 0;
      end else begin
        if (lat_active) lat++;
        if (tx_start) begin
          check("tx_start_width", prev_start, 0);
          if (lat_active) check("done_to_start_latency", lat, 2);
          lat_active = 0;
          if (exp_bytes.size() == 0) check("unexpected_tx_start", 1, 0);
          else check($sformatf("frame_byte%0d", frame_pos), tx_data, exp_bytes.pop_front());
          frame_pos = (frame_pos + 1) % FRAME_BYTES;
        end
        if (tx_done && frame_pos != 0) begin
          lat_active = 1;
          lat = 0;
        end
        prev_start = tx_start;
      end
      if (finish_req && !final_done) begin
        check("bytes_left", exp_bytes.size(), 0);
        check("commands_left", exp_en.size(), 0);
        check("idle_at_end", busy, 0);
        final_done = 1;
      end
    end
  end

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned n);
    longint s;
    s = longint'(a) + longint'(n);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : int'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      tick();
    end
    $display("FAIL wait_idle: busy still %0b after 300 cycles, expected 0", busy);
    $fatal(1, "stuck busy");
  endtask

  task automatic wait_tx_start(input int b);
    for (int i = 0; i < 300; i++) begin
      if (tx_start) return;
      tick();
    end
    $display("FAIL wait_tx_start: byte %0d tx_start still %0b after 300 cycles, expected 1", b, tx_start);
    $fatal(1, "no tx_start");
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_reset();
    wait_idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cnt_model = 0;
    tick();
  endtask

  // Issue one command, predict its frame, and act as the UART TX side for it.
  task automatic do_cmd(input bit is_run, input int h, input logic [15:0] acc,
                        input logic [10:0] pc, input bit junk, input bit collide,
                        input int abort_at);
    int unsigned n;
    logic [31:0] c;
    wait_idle();
    bip_acc = acc;
    bip_pc  = pc;
    en_base = en_cnt;
    halt_at = is_run ? h : $urandom_range(0, 1);
    n = is_run ? h : 1;
    cnt_model = sat_add(cnt_model, n);
    c = cnt_model;
    exp_bytes.push_back(acc[15:8]);
    exp_bytes.push_back(acc[7:0]);
    exp_bytes.push_back({5'b0, pc[10:8]});
    exp_bytes.push_back(pc[7:0]);
    exp_bytes.push_back(c[31:24]);
    exp_bytes.push_back(c[23:16]);
    exp_bytes.push_back(c[15:8]);
    exp_bytes.push_back(c[7:0]);
    exp_en.push_back(int'(n));
    send_byte(is_run ? CMD_RUN : CMD_STEP);
    for (int b = 0; b < FRAME_BYTES; b++) begin
      wait_tx_start(b);
      if (b == abort_at) begin
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        cnt_model = 0;
        tick();
        return;
      end
      bip_acc = DATA_W'($urandom);
      bip_pc  = PC_W'($urandom);
      if (junk && b == 2) begin
        send_byte(8'h78);
        send_byte(CMD_RUN);
      end
      repeat ($urandom_range(0, 3)) tick();
      tx_done = 1'b1;
      if (collide && b == FRAME_BYTES - 1) begin
        rx_data = CMD_RUN;
        rx_done = 1'b1;
      end
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] jb;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    do_cmd(1, 2, 16'hBEEF, 11'h123, 0, 0, 3);
    do_cmd(1, 5, 16'h00AB, 11'h005, 0, 0, -1);

    pulse_reset();
    for (int i = 0; i < 3; i++) do_cmd(0, 1, 16'h1234, 11'h7FF, 0, 0, -1);

    do_cmd(1, 1, 16'hCAFE, 11'h400, 0, 0, -1);
    do_cmd(1, 3, 16'h5A5A, 11'h0F0, 1, 1, -1);

    for (int i = 0; i < 4; i++) begin
      jb = 8'($urandom_range(0, 255));
      if (jb == CMD_RUN || jb == CMD_STEP) jb = 8'h00;
      send_byte(jb);
      tick();
    end

    for (int i = 0; i < 25; i++) begin
      do_cmd(1'($urandom_range(0, 1)), $urandom_range(1, 6), 16'($urandom),
             11'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    wait_idle();
    force dut.cnt_q = '1;
    tick();
    release dut.cnt_q;
    cnt_model = 32'hFFFF_FFFF;
    do_cmd(0, 1, 16'h0F0F, 11'h3C3, 0, 0, -1);
    do_cmd(1, 2, 16'hF00D, 11'h055, 0, 0, -1);

    wait_idle();
    repeat (5) tick();
    finish_req = 1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_debug_unit.md
Name: bip_debug_unit

Overview:
- Run-control and reporting stage placed directly around the BIP core.
- Receives command bytes from the UART RX side and gates the BIP with a clock-enable.
- When the BIP halts, or a single step completes, it snapshots the accumulator, program counter and cycle count.
- Streams the snapshot as a fixed 8-byte frame to the UART TX side through a start/done handshake.

Parameters:
- DATA_W, 16, BIP accumulator width.
- PC_W, 11, BIP program-counter width (≤16).
- CNT_W, 32, enabled-cycle counter width (multiple of 8).
- CMD_RUN, 8'h67, command byte 'g': run until halt.
- CMD_STEP, 8'h73, command byte 's': execute one cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx_data  in  8  received command byte, valid when rx_done=1.
- rx_done  in  1  one-cycle pulse, new byte on rx_data.
- bip_halt  in  1  BIP has executed HLT (level).
- bip_acc  in  DATA_W  BIP accumulator.
- bip_pc  in  PC_W  BIP program counter.
- bip_enable  out  1  clock-enable to BIP core.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle request to UART TX.
- tx_done  in  1  one-cycle pulse, TX finished current byte.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asserted, async): state=IDLE, bip_enable=0, tx_start=0, tx_data=0, busy=0, cycle counter=0, snapshot registers=0. Any transfer in progress is abandoned. No partial frame is resumed after release.
- All outputs are registered.
- States: IDLE, RUN, STEP, SEND, WAIT_DONE.
- IDLE:
  - rx_done with rx_data==CMD_RUN -> RUN; bip_enable=1 from the next edge.
  - rx_done with rx_data==CMD_STEP -> STEP; bip_enable=1 for exactly one cycle.
  - Any other byte is ignored.
- RUN:
  - Counter increments (saturating at all-ones) on every edge in RUN.
  - On the edge where bip_halt=1 is sampled:
    - snapshot acc, pc, and counter+1 (saturated);
    - bip_enable=0;
    - byte index=0;
    - -> SEND.
  - If bip_halt is already 1 on entry, the first RUN edge snapshots, so the count rises by 1.
- STEP: on the single edge, counter+1 (saturated), snapshot (halt ignored), bip_enable=0, byte index=0, -> SEND.
- Counter is cumulative across commands; only reset clears it.
- SEND: drive tx_data=frame[idx], pulse tx_start for one cycle, -> WAIT_DONE.
- WAIT_DONE:
  - On tx_done: if idx==7 -> IDLE; else idx+1 -> SEND.
  - Latency from tx_done to the next tx_start is 2 edges.
- Frame order, MSB first:
  - byte0 = acc[15:8], byte1 = acc[7:0];
  - byte2 = zero-extended pc[PC_W-1:8], byte3 = pc[7:0];
  - bytes 4..7 = count[31:24], [23:16], [15:8], [7:0].
- rx_done outside IDLE is ignored (no queueing). tx_done outside WAIT_DONE is ignored.
- A command arriving in the same cycle as the return to IDLE is ignored. Only commands sampled while in IDLE count.
- Snapshot values are stable for the whole frame, regardless of later BIP input changes.

Decomposition:
- Shared package bip_dbg_pkg:
  - state enum;
  - CMD_RUN and CMD_STEP constants;
  - FRAME_BYTES=8;
  - index width constant (3).
- One sub-module, bip_dbg_frame_sel:
  - combinational selection of the snapshot byte from the 3-bit index;
  - instantiated once inside bip_debug_unit.

Test Plan:
- Reset low mid-WAIT_DONE (idx=3) -> tx_start=0, bip_enable=0, busy=0 immediately. After release, a 'g' produces a fresh frame starting at byte0.
- 'g' with a BIP model that halts after 5 enabled cycles, acc=16'h00AB, pc=11'h005 -> bytes 00 AB 00 05 00 00 00 05. tx_start pulses exactly 8 times, one per tx_done.
- Three 's' commands, halt held 0, acc=16'h1234, pc=11'h7FF -> three frames. The last is 12 34 07 FF 00 00 00 03. bip_enable is high exactly 1 cycle per command.
- 'g' with bip_halt already 1 -> immediate snapshot; count field = previous count+1. bip_enable high for 1 cycle.
- Bytes 'x', then 'g', during SEND -> ignored; no extra frame; state returns to IDLE after byte7.
- Counter preloaded to all-ones via force, then 's' -> count field FF FF FF FF (saturated, no wrap).
